// File: rtl/fpu_pkg.sv
// Shared FPU definitions: normalize/round FSM states, exponent limits,
// mantissa bit positions and special encodings.
package fpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } norm_state_t;

  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;

  localparam int CARRY  = 27;
  localparam int HIDDEN = 26;
  localparam int GUARD  = 2;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] INF  = 32'h7F80_0000;

endpackage

// File: rtl/fp32_norm_round_if.sv
// Operand/result bus of the FP32 normalize-and-round stage.
// Handshake: a transfer happens on a rising edge where valid && ready; the
// sender holds its payload stable while valid is high and ready is low.
interface fp32_norm_round_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic            in_sign;
  logic [9:0]      in_exp;
  logic [27:0]     in_mant;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            overflow;
  logic            underflow;
  logic            inexact;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, out_ready,
    input  in_ready, out_valid, result, overflow, underflow, inexact
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, out_ready,
    output in_ready, out_valid, result, overflow, underflow, inexact
  );
endinterface

// File: rtl/fpu_lzc28.sv
// 28-bit leading-zero counter (count = 28 for an all-zero input).
// Only elaborated when FPU_NORM_LZC_EN is defined.
`ifdef FPU_NORM_LZC_EN
module fpu_lzc28 (
  input  logic [27:0] value,
  output logic [4:0]  count
);
  always_comb begin
    count = 5'd28;
    for (int i = 0; i < 28; i++) begin
      if (value[i]) count = 5'(27 - i);
    end
  end
endmodule
`endif

// File: rtl/fp32_norm_round.sv
// FP32 normalize + round-to-nearest-even stage with flush-to-zero.
// FPU_NORM_LZC_EN selects single-cycle LZC normalization instead of 1 bit/cycle.
import fpu_pkg::*;

module fp32_norm_round #(
  parameter int XLEN  = 32,
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                clk,
  input  logic                rst_n,
  fp32_norm_round_if.slave    bus,
  output norm_state_t         state
);

  norm_state_t        state_q, state_d;
  logic               sign_q, zero_q;
  logic signed [10:0] exp_q, norm_exp, rnd_exp;
  logic [27:0]        mant_q, norm_mant;
  logic               norm_done;
  logic [XLEN-1:0]    result_q, rnd_result;
  logic               overflow_q, underflow_q, inexact_q;
  logic               rnd_ovf, rnd_unf, rnd_inx, round_up, rnd_hidden;
  logic [24:0]        rnd_sum;
  logic [MAN_W-1:0]   rnd_frac;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.in_valid)  state_d = ST_NORM;
      ST_NORM:  if (norm_done)     state_d = ST_ROUND;
      ST_ROUND:                    state_d = ST_DONE;
      ST_DONE:  if (bus.out_ready) state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == ST_IDLE);
    bus.out_valid = (state_q == ST_DONE);
  end

  assign state         = state_q;
  assign bus.result    = result_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
  assign bus.inexact   = inexact_q;

`ifdef FPU_NORM_LZC_EN
  logic [4:0]         lzc, lz27, shamt;
  logic signed [10:0] room;

  fpu_lzc28 u_lzc (.value(mant_q), .count(lzc));

  // Shift as far as the leading one allows, but never below exponent 1.
  always_comb begin
    norm_mant = mant_q;
    norm_exp  = exp_q;
    norm_done = 1'b1;
    lz27      = lzc - 5'd1;
    room      = exp_q - 11'sd1;
    shamt     = '0;
    if (!zero_q) begin
      if (mant_q[CARRY]) begin
        norm_mant = {1'b0, mant_q[27:2], mant_q[1] | mant_q[0]};
        norm_exp  = exp_q + 11'sd1;
      end else if (exp_q > 11'sd1) begin
        shamt     = (room < $signed({6'b0, lz27})) ? room[4:0] : lz27;
        norm_mant = mant_q << shamt;
        norm_exp  = exp_q - $signed({6'b0, shamt});
      end
    end
  end
`else
  // The last left shift leaves NORM directly, so k = max(1, shifts).
  always_comb begin
    norm_mant = mant_q;
    norm_exp  = exp_q;
    norm_done = 1'b1;
    if (!zero_q) begin
      if (mant_q[CARRY]) begin
        norm_mant = {1'b0, mant_q[27:2], mant_q[1] | mant_q[0]};
        norm_exp  = exp_q + 11'sd1;
      end else if (!mant_q[HIDDEN] && exp_q > 11'sd1) begin
        norm_mant = {mant_q[26:0], 1'b0};
        norm_exp  = exp_q - 11'sd1;
        norm_done = mant_q[HIDDEN-1] || (exp_q <= 11'sd2);
      end
    end
  end
`endif

  always_comb begin
    round_up   = mant_q[GUARD] & (mant_q[1] | mant_q[0] | mant_q[3]);
    rnd_inx    = mant_q[GUARD] | mant_q[1] | mant_q[0];
    rnd_sum    = mant_q[27:3] + {24'b0, round_up};
    rnd_exp    = exp_q;
    rnd_hidden = rnd_sum[23];
    rnd_frac   = rnd_sum[MAN_W-1:0];
    if (rnd_sum[24]) begin
      rnd_exp    = exp_q + 11'sd1;
      rnd_hidden = 1'b1;
      rnd_frac   = rnd_sum[MAN_W:1];
    end
    rnd_ovf = 1'b0;
    rnd_unf = 1'b0;
    if (zero_q) begin
      rnd_result = '0;
    end else if (int'(rnd_exp) >= EXP_MAX) begin
      rnd_ovf    = 1'b1;
      rnd_result = {sign_q, INF[30:0]};
    end else if (int'(rnd_exp) <= 0 || !rnd_hidden) begin
      rnd_unf    = 1'b1;
      rnd_result = {sign_q, {(XLEN-1){1'b0}}};
    end else begin
      rnd_result = {sign_q, rnd_exp[EXP_W-1:0], rnd_frac};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q      <= 1'b0;
      zero_q      <= 1'b0;
      exp_q       <= '0;
      mant_q      <= '0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      inexact_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.in_valid) begin
          sign_q <= bus.in_sign;
          zero_q <= (bus.in_mant == '0);
          exp_q  <= {bus.in_exp[9], bus.in_exp};
          mant_q <= bus.in_mant;
        end
        ST_NORM: begin
          exp_q  <= norm_exp;
          mant_q <= norm_mant;
        end
        ST_ROUND: begin
          result_q    <= rnd_result;
          overflow_q  <= rnd_ovf;
          underflow_q <= rnd_unf;
          inexact_q   <= rnd_inx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_norm_round.sv
// Bench for fp32_norm_round: directed spec vectors, randomized operands with
// backpressure, and reset during normalization, against an arithmetic model.
module tb_fp32_norm_round;
  import fpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  norm_state_t state;
  int          n_checks = 0;
  int          n_errors = 0;

`ifdef FPU_NORM_LZC_EN
  localparam bit LZC_BUILD = 1'b1;
`else
  localparam bit LZC_BUILD = 1'b0;
`endif

  fp32_norm_round_if bus ();

  fp32_norm_round dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .state (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    end
  endtask

  // Value-level model: normalize, RNE, classify; k = cycles spent normalizing.
  function automatic void ref_model(input logic s, input logic [9:0] e_in, input logic [27:0] m_in,
                                    output logic [31:0] r, output logic ovf, output logic unf,
                                    output logic inx, output int k);
    int          e, shifts;
    int unsigned m, q;
    logic        g, rs, lsb;
    e = int'($signed(e_in));
    m = m_in;
    shifts = 0;
    r = '0; ovf = 1'b0; unf = 1'b0; inx = 1'b0; k = 1;
    if (m == 0) return;
    if (m >= (1 << 27)) begin
      m = (m >> 1) | (m & 1);
      e++;
    end else begin
      while (m < (1 << 26) && e > 1) begin
        m = m << 1;
        e--;
        shifts++;
      end
    end
    if (!LZC_BUILD && shifts > 1) k = shifts;
    lsb = m[3];
    g   = m[2];
    rs  = (m & 3) != 0;
    inx = g | rs;
    q = m >> 3;
    if (g && (rs || lsb)) q++;
    if (q >= (1 << 24)) begin
      q = q >> 1;
      e++;
    end
    if (e >= 255) begin
      ovf = 1'b1;
      r = {s, 8'hFF, 23'd0};
    end else if (e <= 0 || q < (1 << 23)) begin
      unf = 1'b1;
      r = {s, 31'd0};
    end else begin
      r = {s, 8'(e), q[22:0]};
    end
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_op(input logic s, input logic [9:0] e, input logic [27:0] m, input int hold);
    logic [31:0] r;
    logic        ovf, unf, inx;
    int          k, edges;
    ref_model(s, e, m, r, ovf, unf, inx, k);
    @(negedge clk);
    check("in_ready_idle", bus.in_ready, 1'b1);
    bus.in_valid  = 1'b1;
    bus.in_sign   = s;
    bus.in_exp    = e;
    bus.in_mant   = m;
    bus.out_ready = 1'b0;
    @(posedge clk);
    edges = 1;
    #1;
    // Keep offering junk while busy; it must be ignored.
    bus.in_sign = 1'($urandom);
    bus.in_exp  = 10'($urandom);
    bus.in_mant = 28'($urandom);
    while (!bus.out_valid && edges < 40) begin
      @(posedge clk);
      edges++;
      #1;
    end
    check("out_valid_seen", bus.out_valid, 1'b1);
    if (!bus.out_valid) begin
      apply_reset();
      return;
    end
    bus.in_valid = 1'b0;
    check("latency", edges, k + 2);
    check("result", bus.result, r);
    check("overflow", bus.overflow, ovf);
    check("underflow", bus.underflow, unf);
    check("inexact", bus.inexact, inx);
    check("in_ready_busy", bus.in_ready, 1'b0);
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      check("hold_out_valid", bus.out_valid, 1'b1);
      check("hold_result", bus.result, r);
      check("hold_flags", {bus.overflow, bus.underflow, bus.inexact}, {ovf, unf, inx});
      check("hold_in_ready", bus.in_ready, 1'b0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("out_valid_cleared", bus.out_valid, 1'b0);
    check("in_ready_return", bus.in_ready, 1'b1);
  endtask

  initial begin
    logic        s;
    logic [9:0]  e;
    logic [27:0] m;

    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_exp    = '0;
    bus.in_mant   = '0;
    bus.out_ready = 1'b0;
    apply_reset();
    #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_result", bus.result, 32'h0);
    check("rst_flags", {bus.overflow, bus.underflow, bus.inexact}, 3'b000);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_state", 32'(state), 32'(ST_IDLE));

    run_op(1'b0, 10'd127, 28'h2000000, 0);
    run_op(1'b0, 10'd127, 28'hA000000, 0);
    run_op(1'b0, 10'd127, 28'h4000004, 0);
    run_op(1'b0, 10'd127, 28'h400000C, 0);
    run_op(1'b0, 10'd254, 28'h8000000, 0);
    run_op(1'b1, 10'd254, 28'h8000000, 0);
    run_op(1'b0, 10'd127, 28'h0000000, 0);
    run_op(1'b0, 10'd3,   28'h0000100, 0);
    run_op(1'b0, 10'd127, 28'h7FFFFFC, 0);
    run_op(1'b0, 10'd254, 28'h7FFFFFC, 0);
    run_op(1'b1, 10'd0,   28'h4000000, 0);
    run_op(1'b0, 10'd100, 28'h0000001, 0);
    run_op(1'b1, 10'd130, 28'h1234567, 10);

    // Reset while the operation is still normalizing.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_sign  = 1'b0;
    bus.in_exp   = 10'd100;
    bus.in_mant  = 28'h0000001;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("mid_state_norm", 32'(state), 32'(ST_NORM));
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 1'b0);
    check("mid_rst_in_ready", bus.in_ready, 1'b1);
    check("mid_rst_result", bus.result, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rel_in_ready", bus.in_ready, 1'b1);
    check("mid_rel_out_valid", bus.out_valid, 1'b0);
    run_op(1'b0, 10'd127, 28'h2000000, 0);

    for (int i = 0; i < 200; i++) begin
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       e = 10'($urandom_range(0, 1023));
        1:       e = 10'($urandom_range(100, 160));
        2:       e = 10'($urandom_range(240, 260));
        default: e = 10'($urandom_range(0, 30));
      endcase
      if ($urandom_range(0, 7) == 0) m = 28'h7FFFFF8 | 28'($urandom_range(0, 7));
      else                           m = 28'($urandom) >> $urandom_range(0, 27);
      run_op(s, e, m, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
